mc_controller: RTL and testbench

- Multi-cycle main control unit that drives the processor datapath.
- Consumes the instruction opcode and funct fields plus the ALU zero flag from the datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Emits every datapath control strobe; also keeps a retired-instruction counter and a sticky illegal-opcode flag.

---
 rtl/mc_controller.sv | 274 +++++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller -- multi-cycle main control unit for the processor datapath.
//
// Walks each instruction through FETCH, DECODE and the execute/memory/
// writeback states that its opcode needs. All datapath strobes are
// Moore-decoded from the state register (plus Funct/Insto where a state's
// ALU operation depends on them). The block also keeps a retired-instruction
// counter and a sticky flag for unsupported opcodes or R-type functs.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-low reset
//   Insto[5:0]           opcode field Inst[31:26]
//   Funct[5:0]           funct field Inst[5:0]
//   zero                 ALU zero flag (qualification happens in the datapath)
//   PCWrite, PCWriteCond PC load strobes (unconditional / beq)
//   IorD                 memory address select (0=PC, 1=ALUOut)
//   MemRead, MemWrite    memory strobes
//   IRWrite              instruction register load
//   MemtoReg[1:0]        write data select (0=ALUOut, 1=MDR, 2=PC)
//   RegDst[1:0]          write register select (0=rt, 1=rd, 2=r31)
//   RegWrite             register file write
//   ALUSrcA              ALU A select (0=PC, 1=rs)
//   ALUSrcB[1:0]         ALU B select (0=rt, 1=4, 2=SE(imm), 3=SE(imm)<<2)
//   ALUop[2:0]           000 add, 001 sub, 010 and, 011 or, 100 slt
//   PCSrc[1:0]           next-PC select (0=ALU, 1=ALUOut, 2=jump, 3=rs)
//   illegal              sticky unsupported-instruction flag
//   instret[CNT_W-1:0]   retired-instruction count (wraps)
module mc_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Insto,
    input  logic [5:0]       Funct,
    input  logic             zero,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUop,
    output logic [1:0]       PCSrc,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEM_RD = 4'd3,
        S_WB_MEM = 4'd4,
        S_MEM_WR = 4'd5,
        S_EXEC_R = 4'd6,
        S_WB_R   = 4'd7,
        S_EXEC_I = 4'd8,
        S_WB_I   = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13
    } state_t;

    // jr is steered to its own state from DECODE, so it is not an ALU funct.
    function automatic logic funct_ok(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
            default:                               funct_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        case (fn)
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_alu = ALU_ADD;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    // zero is qualified by PCWriteCond in the datapath, not used here.
    logic unused_zero_s;
    assign unused_zero_s = zero;

    // Next-state, sticky-illegal and retire-count computation.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        instret_d = instret_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (Insto)
                    OP_R: begin
                        if (Funct == FN_JR) begin
                            state_d = S_JR;
                        end else begin
                            state_d = S_EXEC_R;
                        end
                    end
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_ADDI, OP_SLTI: state_d = S_EXEC_I;
                    OP_J:             state_d = S_JUMP;
                    OP_JAL:           state_d = S_JAL;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (Insto == OP_LW) begin
                    state_d = S_MEM_RD;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_MEM_RD: state_d = S_WB_MEM;
            S_EXEC_R: begin
                if (funct_ok(Funct)) begin
                    state_d = S_WB_R;
                end else begin
                    // Abandoned without retiring.
                    state_d   = S_FETCH;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC_I: state_d = S_WB_I;
            S_WB_MEM, S_MEM_WR, S_WB_R, S_WB_I,
            S_BRANCH, S_JUMP, S_JAL, S_JR: begin
                state_d   = S_FETCH;
                instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State, sticky flag and retire counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    assign illegal = illegal_q;
    assign instret = instret_q;

    // Moore strobe decode; gated by rst so an abort drops every strobe at once.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 2'd0;
        RegDst      = 2'd0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        ALUop       = ALU_ADD;
        PCSrc       = 2'd0;
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    ALUSrcB = 2'd1;
                    PCWrite = 1'b1;
                end
                S_DECODE: ALUSrcB = 2'd3;
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                end
                S_MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_WB_MEM: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'd1;
                end
                S_MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUop   = funct_alu(Funct);
                end
                S_WB_R: begin
                    RegWrite = 1'b1;
                    RegDst   = 2'd1;
                end
                S_EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                    if (Insto == OP_SLTI) begin
                        ALUop = ALU_SLT;
                    end else begin
                        ALUop = ALU_ADD;
                    end
                end
                S_WB_I: RegWrite = 1'b1;
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUop       = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSrc       = 2'd1;
                end
                S_JUMP: begin
                    PCWrite = 1'b1;
                    PCSrc   = 2'd2;
                end
                S_JAL: begin
                    PCWrite  = 1'b1;
                    PCSrc    = 2'd2;
                    RegWrite = 1'b1;
                    RegDst   = 2'd2;
                    MemtoReg = 2'd2;
                end
                S_JR: begin
                    ALUSrcA = 1'b1;
                    PCWrite = 1'b1;
                    PCSrc   = 2'd3;
                end
                default: PCWrite = 1'b0;
            endcase
        end else begin
            PCWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed testbench for mc_controller: walks every instruction class,
// mid-instruction reset, illegal opcode and illegal funct.
module tb_mc_controller;

    logic        clk;
    logic        rst;
    logic [5:0]  Insto;
    logic [5:0]  Funct;
    logic        zero;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0]  MemtoReg, RegDst;
    logic        RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUop;
    logic [1:0]  PCSrc;
    logic        illegal;
    logic [31:0] instret;

    int tests_run = 0;
    int tests_failed = 0;

    mc_controller #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .Insto(Insto), .Funct(Funct), .zero(zero),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop), .PCSrc(PCSrc),
        .illegal(illegal), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs the expected strobes in the same order as the observed vector.
    function automatic logic [18:0] ctl(
        input logic pcw, input logic pcwc, input logic iord, input logic mr,
        input logic mw, input logic irw, input logic [1:0] m2r,
        input logic [1:0] rdst, input logic rw, input logic asa,
        input logic [1:0] asb, input logic [2:0] aop, input logic [1:0] pcs);
        ctl = {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, pcs};
    endfunction

    logic [18:0] obs_ctl;
    assign obs_ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                      MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSrc};

    logic [18:0] E_ZERO, E_FETCH, E_DECODE, E_MEMADR, E_MEM_RD, E_WB_MEM;
    logic [18:0] E_MEM_WR, E_EXEC_SUB, E_EXEC_BAD, E_WB_R, E_ADDI, E_SLTI;
    logic [18:0] E_WB_I, E_BRANCH, E_JUMP, E_JAL, E_JR;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next negative edge, then compare the strobe vector.
    task automatic step(input string tag, input logic [18:0] exp);
        @(negedge clk);
        chk(tag, {13'd0, obs_ctl}, {13'd0, exp});
    endtask

    initial begin
        E_ZERO     = ctl(0,0,0,0,0,0,2'd0,2'd0,0,0,2'd0,3'd0,2'd0);
        E_FETCH    = ctl(1,0,0,1,0,1,2'd0,2'd0,0,0,2'd1,3'd0,2'd0);
        E_DECODE   = ctl(0,0,0,0,0,0,2'd0,2'd0,0,0,2'd3,3'd0,2'd0);
        E_MEMADR   = ctl(0,0,0,0,0,0,2'd0,2'd0,0,1,2'd2,3'd0,2'd0);
        E_MEM_RD   = ctl(0,0,1,1,0,0,2'd0,2'd0,0,0,2'd0,3'd0,2'd0);
        E_WB_MEM   = ctl(0,0,0,0,0,0,2'd1,2'd0,1,0,2'd0,3'd0,2'd0);
        E_MEM_WR   = ctl(0,0,1,0,1,0,2'd0,2'd0,0,0,2'd0,3'd0,2'd0);
        E_EXEC_SUB = ctl(0,0,0,0,0,0,2'd0,2'd0,0,1,2'd0,3'd1,2'd0);
        E_EXEC_BAD = ctl(0,0,0,0,0,0,2'd0,2'd0,0,1,2'd0,3'd0,2'd0);
        E_WB_R     = ctl(0,0,0,0,0,0,2'd0,2'd1,1,0,2'd0,3'd0,2'd0);
        E_ADDI     = ctl(0,0,0,0,0,0,2'd0,2'd0,0,1,2'd2,3'd0,2'd0);
        E_SLTI     = ctl(0,0,0,0,0,0,2'd0,2'd0,0,1,2'd2,3'd4,2'd0);
        E_WB_I     = ctl(0,0,0,0,0,0,2'd0,2'd0,1,0,2'd0,3'd0,2'd0);
        E_BRANCH   = ctl(0,1,0,0,0,0,2'd0,2'd0,0,1,2'd0,3'd1,2'd1);
        E_JUMP     = ctl(1,0,0,0,0,0,2'd0,2'd0,0,0,2'd0,3'd0,2'd2);
        E_JAL      = ctl(1,0,0,0,0,0,2'd2,2'd2,1,0,2'd0,3'd0,2'd2);
        E_JR       = ctl(1,0,0,0,0,0,2'd0,2'd0,0,1,2'd0,3'd0,2'd3);

        rst = 1'b0; Insto = 6'b100011; Funct = 6'b000000; zero = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ctl", {13'd0, obs_ctl}, {13'd0, E_ZERO});
        chk("reset_instret", instret, 32'd0);
        chk("reset_illegal", {31'd0, illegal}, 32'd0);

        // lw interrupted in MEM_RD by a 3-cycle reset
        @(posedge clk); #1 rst = 1'b1;
        step("lwa_fetch", E_FETCH);
        step("lwa_decode", E_DECODE);
        step("lwa_memadr", E_MEMADR);
        step("lwa_memrd", E_MEM_RD);
        #1 rst = 1'b0;
        #1 chk("abort_ctl", {13'd0, obs_ctl}, {13'd0, E_ZERO});
        repeat (3) begin
            step("abort_hold", E_ZERO);
            chk("abort_instret", instret, 32'd0);
        end
        @(posedge clk); #1 rst = 1'b1;

        // lw: 5 cycles
        step("lw_fetch", E_FETCH);
        step("lw_decode", E_DECODE);
        step("lw_memadr", E_MEMADR);
        step("lw_memrd", E_MEM_RD);
        step("lw_wbmem", E_WB_MEM);
        chk("lw_instret_before", instret, 32'd0);
        step("sub_fetch", E_FETCH);
        chk("lw_instret", instret, 32'd1);

        // R-type sub: 4 cycles
        Insto = 6'b000000; Funct = 6'b100010;
        step("sub_decode", E_DECODE);
        step("sub_exec", E_EXEC_SUB);
        step("sub_wbr", E_WB_R);
        step("beq_fetch", E_FETCH);
        chk("sub_instret", instret, 32'd2);

        // beq: 3 cycles
        Insto = 6'b000100;
        step("beq_decode", E_DECODE);
        step("beq_branch", E_BRANCH);
        step("jal_fetch", E_FETCH);
        chk("beq_instret", instret, 32'd3);

        // jal: 3 cycles
        Insto = 6'b000011;
        step("jal_decode", E_DECODE);
        step("jal_jal", E_JAL);
        step("jr_fetch", E_FETCH);
        chk("jal_instret", instret, 32'd4);

        // jr: 3 cycles, never RegWrite
        Insto = 6'b000000; Funct = 6'b001000;
        step("jr_decode", E_DECODE);
        step("jr_jr", E_JR);
        step("sw_fetch", E_FETCH);
        chk("jr_instret", instret, 32'd5);

        // sw: 4 cycles
        Insto = 6'b101011;
        step("sw_decode", E_DECODE);
        step("sw_memadr", E_MEMADR);
        step("sw_memwr", E_MEM_WR);
        step("ill_fetch", E_FETCH);
        chk("sw_instret", instret, 32'd6);
        chk("pre_illegal", {31'd0, illegal}, 32'd0);

        // illegal opcode: 2 cycles, not retired
        Insto = 6'b111111;
        step("ill_decode", E_DECODE);
        step("addi_fetch", E_FETCH);
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        chk("ill_instret", instret, 32'd6);

        // addi after illegal: flag stays set
        Insto = 6'b001000;
        step("addi_decode", E_DECODE);
        step("addi_exec", E_ADDI);
        step("addi_wbi", E_WB_I);
        step("slti_fetch", E_FETCH);
        chk("addi_instret", instret, 32'd7);
        chk("addi_illegal_sticky", {31'd0, illegal}, 32'd1);

        // slti
        Insto = 6'b001010;
        step("slti_decode", E_DECODE);
        step("slti_exec", E_SLTI);
        step("slti_wbi", E_WB_I);
        step("j_fetch", E_FETCH);
        chk("slti_instret", instret, 32'd8);

        // j
        Insto = 6'b000010;
        step("j_decode", E_DECODE);
        step("j_jump", E_JUMP);
        step("j_next_fetch", E_FETCH);
        chk("j_instret", instret, 32'd9);

        // reset clears the sticky flag and counter
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst2_illegal", {31'd0, illegal}, 32'd0);
        chk("rst2_instret", instret, 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // unsupported funct: abandoned after EXEC_R, sets illegal, not retired
        Insto = 6'b000000; Funct = 6'b111111;
        step("badfn_fetch", E_FETCH);
        step("badfn_decode", E_DECODE);
        step("badfn_exec", E_EXEC_BAD);
        chk("badfn_illegal_pre", {31'd0, illegal}, 32'd0);
        step("badfn_next_fetch", E_FETCH);
        chk("badfn_illegal", {31'd0, illegal}, 32'd1);
        chk("badfn_instret", instret, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
